// File: rtl/serial_sub_arbiter.sv
// Bit-serial subtractor shared by two requesters through a round-robin front end.
// One operation computes a - b over WIDTH cycles, LSB first, and returns the
// result tagged with the id of the requester that issued it.
module serial_sub_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             owner,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q, res_next;
  logic [CntW-1:0]  cnt_q;
  logic             bin_q, own_q, last_q;
  logic             start, sel1;
  logic             hs1_d, hs1_b, hs2_d, hs2_b, bout;
  logic             last_bit;

  // Arbitration: only in IDLE; on a tie serve the requester not served last.
  always_comb begin
    start = 1'b0;
    sel1  = 1'b0;
    if (state_q == StIdle && !rst) begin
      start = req0 | req1;
      if (req0 && req1) begin
        sel1 = ~last_q;
      end else begin
        sel1 = req1;
      end
    end
  end

  assign gnt0 = start & ~sel1;
  assign gnt1 = start & sel1;

  // Full subtractor cell: two half subtractors, borrows ORed.
  always_comb begin
    hs1_d = a_sh_q[0] ^ b_sh_q[0];
    hs1_b = ~a_sh_q[0] & b_sh_q[0];
    hs2_d = hs1_d ^ bin_q;
    hs2_b = ~hs1_d & bin_q;
    bout  = hs1_b | hs2_b;
  end

  // New difference bit enters at the MSB end of the result register.
  if (WIDTH == 1) begin : g_res_w1
    assign res_next = hs2_d;
  end else begin : g_res_wn
    assign res_next = {hs2_d, res_sh_q[WIDTH-1:1]};
  end

  assign last_bit = (cnt_q == CntLast);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand load on grant, one bit per RUN cycle, result publish on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      own_q    <= 1'b0;
      last_q   <= 1'b1;
      diff     <= '0;
      borrow   <= 1'b0;
      owner    <= 1'b0;
    end else if (start) begin
      a_sh_q <= sel1 ? a1 : a0;
      b_sh_q <= sel1 ? b1 : b0;
      bin_q  <= 1'b0;
      cnt_q  <= '0;
      own_q  <= sel1;
      last_q <= sel1;
    end else if (state_q == StRun) begin
      a_sh_q   <= a_sh_q >> 1;
      b_sh_q   <= b_sh_q >> 1;
      res_sh_q <= res_next;
      bin_q    <= bout;
      cnt_q    <= cnt_q + 1'b1;
      if (last_bit) begin
        diff   <= res_next;
        borrow <= bout;
        owner  <= own_q;
      end
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_serial_sub_arbiter.sv
// Directed bench for serial_sub_arbiter: an 8-bit instance for arbitration,
// timing and reset behaviour, and a 4-bit instance swept over all operand pairs.
module tb_serial_sub_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 8-bit instance
  logic       req0, req1, gnt0, gnt1, busy, done, owner, borrow;
  logic [7:0] a0, b0, a1, b1, diff;

  serial_sub_arbiter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .owner(owner), .diff(diff), .borrow(borrow)
  );

  // 4-bit instance, requester 0 only
  logic       req4, g40, g41, busy4, done4, owner4, borrow4;
  logic [3:0] a4, b4, diff4;
  logic [3:0] zero4 = 4'd0;
  logic       zero1 = 1'b0;

  serial_sub_arbiter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0(req4), .a0(a4), .b0(b4),
    .req1(zero1), .a1(zero4), .b1(zero4),
    .gnt0(g40), .gnt1(g41), .busy(busy4), .done(done4),
    .owner(owner4), .diff(diff4), .borrow(borrow4)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Poll from the current cycle until a grant appears.
  task automatic wait_grant(input string tag, output int id, output int gcyc);
    bit seen;
    seen = 1'b0;
    id   = -1;
    gcyc = cyc;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (gnt0 || gnt1) begin
        seen = 1'b1;
        id   = gnt1 ? 1 : 0;
        gcyc = cyc;
        check({tag, "_onehot"}, {31'd0, gnt0 & gnt1}, 32'd0);
      end else begin
        step();
      end
    end
    if (!seen) check({tag, "_gnt_timeout"}, 32'd0, 32'd1);
  endtask

  // Advance until done; flag any grant seen on the way.
  task automatic wait_done(input string tag, input int gcyc, output int lat, output bit stray);
    bit seen;
    seen  = 1'b0;
    stray = 1'b0;
    lat   = -1;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (gnt0 || gnt1) stray = 1'b1;
      if (done) begin
        seen = 1'b1;
        lat  = cyc - gcyc;
      end
    end
    if (!seen) check({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  // Single-requester operation on the 8-bit instance.
  task automatic run_op(input string tag, input bit id, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input bit eb);
    int gid, gc, lat;
    bit stray;
    if (id) begin
      a1 = a; b1 = b; req1 = 1'b1;
    end else begin
      a0 = a; b0 = b; req0 = 1'b1;
    end
    wait_grant(tag, gid, gc);
    check({tag, "_gid"}, gid, {31'd0, id});
    step();
    if (id) req1 = 1'b0; else req0 = 1'b0;
    wait_done(tag, gc, lat, stray);
    check({tag, "_lat"}, lat, 32'd9);
    check({tag, "_stray"}, {31'd0, stray}, 32'd0);
    check({tag, "_res"}, {22'd0, owner, borrow, diff}, {22'd0, id, eb, ed});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gid, gc, lat, prev_gc;
    bit stray, seen;

    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    req4 = 1'b0; a4 = '0; b4 = '0;
    step();
    step();
    check("reset_outs", {18'd0, gnt0, gnt1, busy, done, owner, borrow, diff}, 32'd0);

    // Tie on reset release: requester 0 wins first.
    a0 = 8'd10; b0 = 8'd3; a1 = 8'd3; b1 = 8'd10;
    req0 = 1'b1; req1 = 1'b1;
    #1;
    check("reset_gnt_held", {30'd0, gnt0, gnt1}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("tie_first_gnt", {30'd0, gnt0, gnt1}, 32'd2);

    // Fairness with both requesters held.
    prev_gc = 0;
    for (int i = 0; i < 4; i++) begin
      wait_grant("fair", gid, gc);
      check("fair_gid", gid, i % 2);
      if (i > 0) check("fair_spacing", gc - prev_gc, 32'd10);
      prev_gc = gc;
      if (i == 3) begin
        step();
        req0 = 1'b0;
        req1 = 1'b0;
      end
      wait_done("fair", gc, lat, stray);
      check("fair_lat", lat, 32'd9);
      check("fair_stray", {31'd0, stray}, 32'd0);
      check("fair_res", {22'd0, owner, borrow, diff},
            (i % 2 == 1) ? {22'd0, 1'b1, 1'b1, 8'd249} : {22'd0, 1'b0, 1'b0, 8'd7});
    end

    run_op("basic", 1'b0, 8'd200, 8'd55, 8'd145, 1'b0);
    run_op("under", 1'b1, 8'h00, 8'h01, 8'hFF, 1'b1);
    run_op("equal", 1'b1, 8'hA5, 8'hA5, 8'h00, 1'b0);

    // Requester 1 arrives while requester 0 is running.
    a0 = 8'd100; b0 = 8'd30; req0 = 1'b1;
    wait_grant("busy0", gid, gc);
    check("busy0_gid", gid, 32'd0);
    step();
    req0 = 1'b0;
    a1 = 8'd5; b1 = 8'd9; req1 = 1'b1;
    wait_done("busy0", gc, lat, stray);
    check("busy0_stray", {31'd0, stray}, 32'd0);
    check("busy0_lat", lat, 32'd9);
    check("busy0_res", {22'd0, owner, borrow, diff}, {22'd0, 1'b0, 1'b0, 8'd70});
    prev_gc = cyc;
    wait_grant("busy1", gid, gc);
    check("busy1_gid", gid, 32'd1);
    check("busy1_gap", gc - prev_gc, 32'd1);
    step();
    req1 = 1'b0;
    step();
    step();
    check("hold_diff", {22'd0, owner, borrow, diff}, {22'd0, 1'b0, 1'b0, 8'd70});
    wait_done("busy1", gc, lat, stray);
    check("busy1_lat", lat, 32'd9);
    check("busy1_res", {22'd0, owner, borrow, diff}, {22'd0, 1'b1, 1'b1, 8'd252});

    // Asynchronous reset in RUN cycle 4.
    a0 = 8'd50; b0 = 8'd20; req0 = 1'b1;
    wait_grant("mrst", gid, gc);
    step();
    req0 = 1'b0;
    step();
    step();
    step();
    #3 rst = 1'b1;
    #1;
    check("mrst_outs", {18'd0, gnt0, gnt1, busy, done, owner, borrow, diff}, 32'd0);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done || busy) seen = 1'b1;
    end
    check("mrst_no_done", {31'd0, seen}, 32'd0);
    run_op("post_rst", 1'b1, 8'd9, 8'd4, 8'd5, 1'b0);

    // Exhaustive sweep on the 4-bit instance.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        a4 = a[3:0];
        b4 = b[3:0];
        req4 = 1'b1;
        #1;
        check("x4_gnt", {30'd0, g40, g41}, 32'd2);
        step();
        req4 = 1'b0;
        if (a == 0 && b == 0) check("x4_busy", {31'd0, busy4}, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
          if (done4) seen = 1'b1;
          else step();
        end
        if (!seen) check("x4_timeout", 32'd0, 32'd1);
        check("x4_res", {26'd0, owner4, borrow4, diff4},
              {26'd0, 1'b0, (a < b) ? 1'b1 : 1'b0, 4'(a - b)});
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_sub_arbiter.md
# serial_sub_arbiter

Bit-serial subtract engine with a two-port round-robin front end. It shares one full-subtractor cell, built from two half subtractors plus an OR on the borrows, between two requesters. Each accepted operation computes `a - b` over `WIDTH` cycles, LSB first. The result is returned with the id of the requester that owns it. It sits between the requesting datapath blocks and the single subtractor cell, as the only user of that cell.

## Interface
- `WIDTH`, default 8: operand/result width in bits. Must be ≥ 1.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `req0`  in  1  requester 0 operation request. Held until granted.
- `a0`, `b0`  in  WIDTH  requester 0 minuend and subtrahend. Stable while `req0` is high.
- `req1`  in  1  requester 1 operation request.
- `a1`, `b1`  in  WIDTH  requester 1 operands.
- `gnt0`, `gnt1`  out  1  grant. One-cycle, combinational from state and requests. Operands are sampled on the clock edge that ends the grant cycle.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle completion pulse.
- `owner`  out  1  requester id of the current result.
- `diff`  out  WIDTH  result `(a - b) mod 2^WIDTH`.
- `borrow`  out  1  final borrow, i.e. `a < b` unsigned.

## Operation
- **States:** IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE behaviour:**
  - If any request is high, the FSM grants exactly one requester and goes to RUN.
  - If both are high, it grants the requester not served last.
  - The last-served pointer resets to 1, so `req0` wins the first tie.
  - On the grant edge:
    - the selected operands load into internal shift registers;
    - the borrow-in register clears;
    - the bit counter clears;
    - the owner id is latched internally.
- **RUN behaviour:** each cycle processes bit i.
  - `d = a_i ^ b_i ^ bin`
  - `bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin)`
  - `d` shifts into the result shift register at the MSB end. `bout` becomes the next `bin`.
  - After the bit WIDTH-1 edge, `diff`, `borrow` and `owner` update from the internal registers and the FSM goes to DONE.
- **DONE behaviour:** `done` = 1 for this cycle only; no grant is issued. The FSM returns to IDLE on the next edge.
- **Output holding:** `diff`, `borrow` and `owner` change only on the completion edge and hold until the next completion.
- **Requests while busy:** ignored, and `gnt0`/`gnt1` stay 0. A requester keeps `req` high until it sees its grant and may drop it the cycle after.
- **Single requester:** it is granted every time it requests. The pointer only matters on a tie, and it updates on every grant.
- **Counter:** width is `$clog2(WIDTH)` (minimum 1 bit). Terminal count is WIDTH-1. WIDTH=1 gives one RUN cycle.

## Timing
- **Reset values:** `gnt0`, `gnt1`, `busy`, `done`, `owner`, `diff` and `borrow` are all 0; FSM in IDLE; pointer = 1.
- **Reset is asynchronous.** It takes effect immediately, even mid-RUN. The in-flight operation is discarded with no `done` and no output update.
- **Latency:** grant high in cycle t, `done` high in cycle t+WIDTH+1.
- **Throughput:**
  - Minimum request-to-request spacing is WIDTH+2 cycles: grant/IDLE, WIDTH×RUN, DONE.
  - With both requesters continuously requesting, grants alternate 0,1,0,1…, each WIDTH+2 cycles apart.
- **Result validity:** `diff`, `borrow` and `owner` are valid from the `done` cycle onward.

## Test plan
- **Reset:** WIDTH=8, assert `rst` asynchronously between edges → all outputs 0 immediately. `req0` and `req1` both high on release → `gnt0` first.
- **Basic subtract:** `req0`, a0=200, b0=55 → `gnt0` pulse in cycle t, `done` in cycle t+9, diff=145, borrow=0, owner=0.
- **Underflow:** `req1`, a1=8'h00, b1=8'h01 → diff=8'hFF, borrow=1, owner=1. Also a1=b1=8'hA5 → diff=0, borrow=0.
- **Fairness:** `req0` and `req1` held high for 4 operations (a0=10/b0=3, a1=3/b1=10) → grants 0,1,0,1 every 10 cycles, results 7/borrow 0 and 249/borrow 1 alternately.
- **Busy and mid-RUN reset:**
  - `req1` raised during a `req0` RUN → no `gnt1` until IDLE, then its result arrives with owner=1.
  - `rst` pulsed in RUN cycle 4 → no `done`, outputs 0; the next operation is correct.
- **Exhaustive check:** WIDTH=4, all 256 (a,b) pairs through `req0` → diff=(a-b)&15 and borrow=(a<b) for every pair.
